// File: rtl/fetcher.sv
// Instruction fetch FSM: IDLE -> FETCH -> PREDICT -> PUSH, with ROB flush redirect.
// Optional macro FETCHER_PERF_CNT_EN adds the perf_fetched push counter.
module fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_hit,
    input  logic [31:0] ic_instr,
    output logic [31:0] pred_instr,
    output logic [31:0] pred_pc,
    input  logic [31:0] pred_next_pc,
    input  logic        iq_full,
    output logic        iq_push,
    output logic [31:0] iq_instr,
    output logic [31:0] iq_pc,
    output logic [31:0] iq_pred_pc,
    input  logic        rob_flush,
    input  logic [31:0] rob_target_pc
`ifdef FETCHER_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, PREDICT, PUSH} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] pred_pc_q;
    logic [31:0] ic_addr_q;
    logic        ic_req_q;
    logic        in_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            instr_q   <= '0;
            pred_pc_q <= '0;
            ic_addr_q <= '0;
            ic_req_q  <= 1'b0;
        end else if (rdy) begin
            if (rob_flush) begin
                // Flush wins over everything, including a same-cycle ic_hit.
                state    <= IDLE;
                pc       <= rob_target_pc;
                ic_req_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= FETCH;
                        ic_req_q  <= 1'b1;
                        ic_addr_q <= pc;
                    end
                    FETCH: begin
                        if (ic_hit) begin
                            state     <= PREDICT;
                            instr_q   <= ic_instr;
                            pred_pc_q <= pc;
                            ic_req_q  <= 1'b0;
                        end
                    end
                    PREDICT: state <= PUSH;
                    PUSH: begin
                        if (!iq_full) begin
                            state     <= FETCH;
                            pc        <= pred_next_pc;
                            ic_req_q  <= 1'b1;
                            ic_addr_q <= pred_next_pc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Queue-side data is only driven while a push is being offered.
    assign in_push    = (state == PUSH);
    assign iq_push    = in_push && !iq_full && rdy && !rob_flush;
    assign iq_instr   = in_push ? instr_q      : '0;
    assign iq_pc      = in_push ? pc           : '0;
    assign iq_pred_pc = in_push ? pred_next_pc : '0;

    assign ic_req     = ic_req_q;
    assign ic_addr    = ic_addr_q;
    assign pred_instr = instr_q;
    assign pred_pc    = pred_pc_q;

`ifdef FETCHER_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_fetched <= '0;
        else if (iq_push)
            perf_fetched <= perf_fetched + 32'd1;
    end
`endif

endmodule
